// File: rtl/snake_head_stepper.sv
// ---------------------------------------------------------------------------
// snake_head_stepper
//
// Moves the snake head one grid cell every TICK_DIV enabled clock cycles.
// It presents each new position to a downstream draw unit with a
// valid/ready handshake. A reversing direction request (for example
// left -> right) is ignored, so the snake cannot run back into its own neck.
//
// Build option:
//   SNAKE_WRAP_EN  defined   : moves off one edge reappear on the opposite
//                              edge; collide is tied low and HALT is never
//                              entered.
//                  undefined : a move that would leave the grid freezes the
//                              head, sets collide and parks the FSM in HALT
//                              until reset.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   dir_in[2:0] in   requested direction (bit2=1 vertical: bit1 0=up 1=down;
//                    bit2=0 horizontal: bit0 0=left 1=right)
//   enable      in   run/pause for the step tick counter
//   head_ready  in   draw unit accepts the presented head position
//   head_x[7:0] out  head column
//   head_y[6:0] out  head row
//   head_valid  out  new head position presented, held until accepted
//   cur_dir[2:0]out  direction in effect
//   collide     out  sticky edge-collision flag
// ---------------------------------------------------------------------------
module snake_head_stepper #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] dir_in,
  input  logic       enable,
  input  logic       head_ready,
  output logic [7:0] head_x,
  output logic [6:0] head_y,
  output logic       head_valid,
  output logic [2:0] cur_dir,
  output logic       collide
);

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_STEP    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [7:0]  X_RESET   = 8'(GRID_W / 2);
  localparam logic [6:0]  Y_RESET   = 7'(GRID_H / 2);
  localparam logic [7:0]  X_MAX     = 8'(GRID_W - 1);
  localparam logic [6:0]  Y_MAX     = 7'(GRID_H - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  dir_q, dir_d;
  logic        collide_q, collide_d;

  logic [2:0]  dir_sel;
  logic        reversal;
  logic [7:0]  move_x;
  logic [6:0]  move_y;
  logic        off_grid;

  // A request on the same axis as the current heading with the opposite
  // sense would reverse the snake; keep the current heading in that case.
  always_comb begin
    reversal = 1'b0;
    if (dir_in[2] == dir_q[2]) begin
      if (dir_in[2])
        reversal = (dir_in[1] != dir_q[1]);
      else
        reversal = (dir_in[0] != dir_q[0]);
    end
    dir_sel = reversal ? dir_q : dir_in;
  end

  // Candidate position one cell along dir_sel. An edge crossing either
  // wraps or, without wrap, keeps the head in place and flags off_grid.
  always_comb begin
    move_x   = x_q;
    move_y   = y_q;
    off_grid = 1'b0;
    if (dir_sel[2]) begin
      if (dir_sel[1]) begin
        if (y_q == Y_MAX) begin
          if (WRAP) move_y = 7'd0;
          else      off_grid = 1'b1;
        end else begin
          move_y = y_q + 7'd1;
        end
      end else begin
        if (y_q == 7'd0) begin
          if (WRAP) move_y = Y_MAX;
          else      off_grid = 1'b1;
        end else begin
          move_y = y_q - 7'd1;
        end
      end
    end else begin
      if (dir_sel[0]) begin
        if (x_q == X_MAX) begin
          if (WRAP) move_x = 8'd0;
          else      off_grid = 1'b1;
        end else begin
          move_x = x_q + 8'd1;
        end
      end else begin
        if (x_q == 8'd0) begin
          if (WRAP) move_x = X_MAX;
          else      off_grid = 1'b1;
        end else begin
          move_x = x_q - 8'd1;
        end
      end
    end
  end

  // The tick counter only runs in WAIT. STEP and PRESENT hold it at zero,
  // so a slow draw unit stretches the step period and no step is queued.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    collide_d = collide_q;
    case (state_q)
      S_WAIT: begin
        if (enable) begin
          if (cnt_q == TICK_LAST) begin
            cnt_d   = 32'd0;
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_STEP: begin
        cnt_d = 32'd0;
        dir_d = dir_sel;
        if (off_grid) begin
          collide_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          x_d     = move_x;
          y_d     = move_y;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        cnt_d = 32'd0;
        if (head_ready) state_d = S_WAIT;
      end
      default: begin
        cnt_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= 32'd0;
      x_q       <= X_RESET;
      y_q       <= Y_RESET;
      dir_q     <= 3'b000;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      collide_q <= collide_d;
    end
  end

  assign head_x     = x_q;
  assign head_y     = y_q;
  assign cur_dir    = dir_q;
  // Decoded straight from the state register so reset clears it at once.
  assign head_valid = (state_q == S_PRESENT);
`ifdef SNAKE_WRAP_EN
  assign collide    = 1'b0;
`else
  assign collide    = collide_q;
`endif

endmodule

// File: tb/tb_snake_head_stepper.sv
// ---------------------------------------------------------------------------
// tb_snake_head_stepper
//
// Directed bench for snake_head_stepper with TICK_DIV=4, so one step period
// with head_ready high is 6 cycles (4 WAIT, 1 STEP, 1 PRESENT). Outputs are
// sampled on the falling edge. The edge behaviour checked at the end depends
// on SNAKE_WRAP_EN, matching the build of the design.
// ---------------------------------------------------------------------------
module tb_snake_head_stepper;

  logic       clk;
  logic       reset_n;
  logic [2:0] dir_in;
  logic       enable;
  logic       head_ready;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic       head_valid;
  logic [2:0] cur_dir;
  logic       collide;

  int checks;
  int errors;

  snake_head_stepper #(
    .GRID_W  (160),
    .GRID_H  (120),
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dir_in    (dir_in),
    .enable    (enable),
    .head_ready(head_ready),
    .head_x    (head_x),
    .head_y    (head_y),
    .head_valid(head_valid),
    .cur_dir   (cur_dir),
    .collide   (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every input in one place.
  task automatic applyStimulus(input logic rst_n, input logic en,
                               input logic [2:0] dir, input logic rdy);
    reset_n    = rst_n;
    enable     = en;
    dir_in     = dir;
    head_ready = rdy;
  endtask

  // One comparison point; a mismatch bumps errors and reports it.
  task automatic checkOutput(input string tag, input int observed,
                             input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Count falling edges until head_valid is seen high; an expired budget
  // is reported as a failed comparison on head_valid.
  task automatic waitValid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (head_valid !== 1'b1 && cycles < budget);
    if (head_valid !== 1'b1) checkOutput("valid_timeout", head_valid, 1);
  endtask

  initial begin
    int  cyc;
    int  stable;
    int  sawValid;
    checks = 0;
    errors = 0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rst_x", head_x, 80);
    checkOutput("rst_y", head_y, 60);
    checkOutput("rst_valid", head_valid, 0);
    checkOutput("rst_dir", cur_dir, 0);
    checkOutput("rst_collide", collide, 0);

    // Left moves at a 6-cycle cadence; first valid 5 falling edges after release
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);
    waitValid(20, cyc);
    checkOutput("first_latency", cyc, 5);
    checkOutput("step1_x", head_x, 79);
    checkOutput("step1_y", head_y, 60);
    checkOutput("step1_dir", cur_dir, 0);
    waitValid(20, cyc);
    checkOutput("period2", cyc, 6);
    checkOutput("step2_x", head_x, 78);
    waitValid(20, cyc);
    checkOutput("period3", cyc, 6);
    checkOutput("step3_x", head_x, 77);
    checkOutput("step3_y", head_y, 60);

    // Turn up, then right
    dir_in = 3'b100;
    waitValid(20, cyc);
    checkOutput("up_dir", cur_dir, 4);
    checkOutput("up_y", head_y, 59);
    checkOutput("up_x", head_x, 77);
    dir_in = 3'b001;
    waitValid(20, cyc);
    checkOutput("right_dir", cur_dir, 1);
    checkOutput("right_x", head_x, 78);

    // Heading right, left request is a reversal and is ignored
    dir_in = 3'b000;
    waitValid(20, cyc);
    checkOutput("rev_h_dir", cur_dir, 1);
    checkOutput("rev_h_x", head_x, 79);

    // Up is accepted from right
    dir_in = 3'b100;
    waitValid(20, cyc);
    checkOutput("turn_up_dir", cur_dir, 4);
    checkOutput("turn_up_y", head_y, 58);
    checkOutput("turn_up_x", head_x, 79);

    // Heading up, down request is a reversal and is ignored
    dir_in = 3'b110;
    waitValid(20, cyc);
    checkOutput("rev_v_dir", cur_dir, 4);
    checkOutput("rev_v_y", head_y, 57);

    // Backpressure: head_ready low for 10 cycles in PRESENT, enable dropped
    // for part of it; the handshake must hold and nothing is queued.
    @(negedge clk);
    checkOutput("valid_drop", head_valid, 0);
    applyStimulus(1'b1, 1'b1, 3'b100, 1'b0);
    waitValid(20, cyc);
    checkOutput("bp_y", head_y, 56);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable = 1'b0;
      if (i == 7) enable = 1'b1;
      @(negedge clk);
      if (head_valid !== 1'b1 || head_y !== 7'd56 || head_x !== 8'd79 ||
          dut.cnt_q !== 32'd0)
        stable = 0;
    end
    checkOutput("bp_hold_stable", stable, 1);
    head_ready = 1'b1;
    waitValid(20, cyc);
    checkOutput("bp_release_period", cyc, 6);
    checkOutput("bp_next_y", head_y, 55);

    // Reset mid-handshake
    @(negedge clk);
    head_ready = 1'b0;
    waitValid(20, cyc);
    checkOutput("pre_rst_y", head_y, 54);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", head_valid, 0);
    checkOutput("midrst_x", head_x, 80);
    checkOutput("midrst_y", head_y, 60);
    checkOutput("midrst_dir", cur_dir, 0);
    checkOutput("midrst_collide", collide, 0);

    // Run left to column 0; the first step after release again takes 5 edges
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);
    waitValid(20, cyc);
    checkOutput("rerun_latency", cyc, 5);
    for (int i = 1; i < 80; i++) waitValid(20, cyc);
    checkOutput("edge_x", head_x, 0);

`ifdef SNAKE_WRAP_EN
    waitValid(20, cyc);
    checkOutput("wrap_left_x", head_x, 159);
    checkOutput("wrap_collide", collide, 0);
    dir_in = 3'b110;
    for (int i = 0; i < 59; i++) waitValid(20, cyc);
    checkOutput("bottom_y", head_y, 119);
    waitValid(20, cyc);
    checkOutput("wrap_down_y", head_y, 0);
    checkOutput("wrap_down_x", head_x, 159);
`else
    sawValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (head_valid === 1'b1) sawValid = 1;
    end
    checkOutput("halt_no_valid", sawValid, 0);
    checkOutput("halt_collide", collide, 1);
    checkOutput("halt_x", head_x, 0);
    checkOutput("halt_y", head_y, 60);
    checkOutput("halt_state", dut.state_q, 3);
    reset_n = 1'b0;
    #1;
    checkOutput("halt_rst_collide", collide, 0);
    checkOutput("halt_rst_x", head_x, 80);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
